// File: rtl/wkt_sine_source.sv
// Prescaled phase-accumulator sine source: 64-entry quarter-wave ROM feeding a
// three-stage pipeline (accumulate, fold address, ROM read + sign).
module wkt_sine_source #(
    parameter int CLK_DIV = 16000,
    parameter int PHASE_W = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [PHASE_W-1:0] i_step,
    output logic [7:0]         o_sample,
    output logic               o_valid,
    output logic [PHASE_W-1:0] o_phase
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    // round(127*sin(pi*k/128)), k = 63 down to 0 (MSB first)
    localparam logic [64*7-1:0] SINE_TAB = {
        7'd127, 7'd127, 7'd127, 7'd126, 7'd126, 7'd126, 7'd125, 7'd125,
        7'd124, 7'd123, 7'd122, 7'd122, 7'd121, 7'd120, 7'd118, 7'd117,
        7'd116, 7'd115, 7'd113, 7'd112, 7'd111, 7'd109, 7'd107, 7'd106,
        7'd104, 7'd102, 7'd100, 7'd98,  7'd96,  7'd94,  7'd92,  7'd90,
        7'd88,  7'd85,  7'd83,  7'd81,  7'd78,  7'd76,  7'd73,  7'd71,
        7'd68,  7'd65,  7'd63,  7'd60,  7'd57,  7'd54,  7'd51,  7'd49,
        7'd46,  7'd43,  7'd40,  7'd37,  7'd34,  7'd31,  7'd28,  7'd25,
        7'd22,  7'd19,  7'd16,  7'd12,  7'd9,   7'd6,   7'd3,   7'd0
    };

    logic [6:0] w_rom [64];

    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_rom
            assign w_rom[gi] = SINE_TAB[gi*7 +: 7];
        end
    endgenerate

    // Prescaler runs continuously so the tick grid never depends on i_enable.
    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick = (r_cnt == CNT_MAX);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Stage 0: phase accumulator
    logic [PHASE_W-1:0] r_phase;
    logic               r_v0;
    logic               w_advance;

    assign w_advance = w_tick && i_enable;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_phase <= '0;
            r_v0    <= 1'b0;
        end else begin
            r_v0 <= w_advance;
            if (w_advance) begin
                r_phase <= r_phase + i_step;
            end
        end
    end

    // Stage 1: fold the phase onto the quarter-wave table; 63-i == ~i in 6 bits
    logic [1:0] w_quad;
    logic [5:0] w_idx;
    logic [5:0] r_addr;
    logic       r_neg;
    logic       r_v1;

    assign w_quad = r_phase[PHASE_W-1 -: 2];
    assign w_idx  = r_phase[PHASE_W-3 -: 6];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr <= '0;
            r_neg  <= 1'b0;
            r_v1   <= 1'b0;
        end else begin
            r_addr <= w_quad[0] ? ~w_idx : w_idx;
            r_neg  <= w_quad[1];
            r_v1   <= r_v0;
        end
    end

    // Stage 2: registered ROM read with offset-binary sign; sample holds between pulses
    logic [7:0] w_mag;
    logic [7:0] r_sample;
    logic       r_valid;

    assign w_mag = {1'b0, w_rom[r_addr]};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sample <= 8'd128;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= r_v1;
            if (r_v1) begin
                r_sample <= r_neg ? (8'd128 - w_mag) : (8'd128 + w_mag);
            end
        end
    end

    assign o_sample = r_sample;
    assign o_valid  = r_valid;
    assign o_phase  = r_phase;

endmodule

// File: tb/tb_wkt_sine_source.sv
// Scoreboard bench: a CLK_DIV=4 instance and a CLK_DIV=1 instance share stimulus;
// a cycle model predicts each sample and the cycle its o_valid pulse is due.
module tb_wkt_sine_source;

    localparam int DIV = 4;
    localparam int PW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [PW-1:0] step;
    logic [7:0]    s_main, s_fast;
    logic          v_main, v_fast;
    logic [PW-1:0] p_main, p_fast;

    always #5 clk = ~clk;

    wkt_sine_source #(.CLK_DIV(DIV), .PHASE_W(PW)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_step(step),
        .o_sample(s_main), .o_valid(v_main), .o_phase(p_main)
    );

    wkt_sine_source #(.CLK_DIV(1), .PHASE_W(PW)) u_dut_fast (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_step(step),
        .o_sample(s_fast), .o_valid(v_fast), .o_phase(p_fast)
    );

    typedef struct {
        int         due;
        logic [7:0] sample;
    } exp_t;

    exp_t          sb[$];
    exp_t          fsb[$];
    exp_t          me, fe;
    logic [7:0]    obs_s[$];
    int            obs_c[$];
    int            cycle = 0;
    int            tick_count = 0;
    int            m_cnt = 0;
    logic [PW-1:0] m_phase = '0;
    logic [PW-1:0] f_phase = '0;
    int            n_pass = 0;
    int            n_checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // Behavioural sample: fold phase to quarter wave, index 63-i on odd quadrants.
    function automatic logic [7:0] model_sample(input logic [PW-1:0] ph);
        int q, idx, a, mag;
        q   = int'(ph[PW-1 -: 2]);
        idx = int'(ph[PW-3 -: 6]);
        a   = (q == 1 || q == 3) ? 63 - idx : idx;
        mag = $rtoi(127.0 * $sin(3.141592653589793 * a / 128.0) + 0.5);
        if (q >= 2) return 8'(128 - mag);
        return 8'(128 + mag);
    endfunction

    function automatic exp_t make_exp(input int due, input logic [PW-1:0] ph);
        exp_t e;
        e.due    = due;
        e.sample = model_sample(ph);
        return e;
    endfunction

    // Reference model, advanced on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (rst) begin
            m_cnt   <= 0;
            m_phase <= '0;
            f_phase <= '0;
            sb.delete();
            fsb.delete();
        end else begin
            if (m_cnt == DIV - 1) begin
                tick_count <= tick_count + 1;
                if (en) begin
                    m_phase <= PW'(m_phase + step);
                    sb.push_back(make_exp(cycle + 3, PW'(m_phase + step)));
                end
            end
            m_cnt <= (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
            if (en) begin
                f_phase <= PW'(f_phase + step);
                fsb.push_back(make_exp(cycle + 3, PW'(f_phase + step)));
            end
        end
    end

    // Output monitor: pop on each pulse, flag pulses that are late, missing or spurious.
    always @(negedge clk) begin
        if (v_main === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("main_valid_unexpected", 32'(v_main), 32'd0);
            end else begin
                me = sb.pop_front();
                check_eq("main_sample", 32'(s_main), 32'(me.sample));
                check_eq("main_latency", cycle, me.due);
                obs_s.push_back(s_main);
                obs_c.push_back(cycle);
                $display("sample %0d phase 0x%04h at cycle %0d", s_main, p_main, cycle);
            end
        end else if (sb.size() > 0 && sb[0].due <= cycle) begin
            me = sb.pop_front();
            check_eq("main_valid_missing", 32'(v_main), 32'd1);
        end
        if (v_fast === 1'b1) begin
            if (fsb.size() == 0) begin
                check_eq("fast_valid_unexpected", 32'(v_fast), 32'd0);
            end else begin
                fe = fsb.pop_front();
                check_eq("fast_sample", 32'(s_fast), 32'(fe.sample));
                check_eq("fast_latency", cycle, fe.due);
            end
        end else if (fsb.size() > 0 && fsb[0].due <= cycle) begin
            fe = fsb.pop_front();
            check_eq("fast_valid_missing", 32'(v_fast), 32'd1);
        end
    end

    task automatic wait_ticks(input int n);
        int target;
        int budget;
        target = tick_count + n;
        budget = n * DIV * 2 + 10;
        while (tick_count < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (tick_count < target) check_eq("tick_timeout", tick_count, target);
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while ((sb.size() > 0 || fsb.size() > 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        @(negedge clk);
        if (sb.size() > 0) check_eq("drain_timeout", sb.size(), 0);
    endtask

    task automatic clear_obs();
        obs_s.delete();
        obs_c.delete();
    endtask

    initial begin
        int t1_exp[5];
        t1_exp = '{255, 128, 1, 128, 255};
        rst  = 1'b1;
        en   = 1'b0;
        step = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_sample", 32'(s_main), 32'd128);
        check_eq("rst_valid",  32'(v_main), 32'd0);
        check_eq("rst_phase",  32'(p_main), 32'd0);
        rst = 1'b0;

        // Quarter-period steps: 255, 128, 1, 128, 255 at 4-cycle spacing
        clear_obs();
        step = 16'h4000;
        en   = 1'b1;
        wait_ticks(5);
        en = 1'b0;
        drain();
        check_eq("t1_count", obs_s.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < obs_s.size()) check_eq($sformatf("t1_sample%0d", i), 32'(obs_s[i]), t1_exp[i]);
        end
        for (int i = 1; i < obs_c.size(); i++) begin
            check_eq("t1_spacing", obs_c[i] - obs_c[i-1], DIV);
        end
        check_eq("t1_phase", 32'(p_main), 32'h4000);

        // Return phase to zero, then eighth-period steps
        step = 16'hC000;
        en   = 1'b1;
        wait_ticks(1);
        en = 1'b0;
        drain();
        check_eq("t3_start_phase", 32'(p_main), 32'h0000);
        clear_obs();
        step = 16'h2000;
        en   = 1'b1;
        wait_ticks(8);
        en = 1'b0;
        drain();
        check_eq("t3_count", obs_s.size(), 8);
        check_eq("t3_end_phase", 32'(p_main), 32'h0000);

        // Accumulator wrap 0xFFFF -> 0x0000
        step = 16'hFFFF;
        en   = 1'b1;
        wait_ticks(1);
        check_eq("t4_phase_ffff", 32'(p_main), 32'hFFFF);
        step = 16'h0001;
        wait_ticks(1);
        en = 1'b0;
        check_eq("t4_phase_wrap", 32'(p_main), 32'h0000);
        clear_obs();
        drain();
        if (obs_s.size() > 0) check_eq("t4_wrap_sample", 32'(obs_s[obs_s.size()-1]), 32'd128);
        else check_eq("t4_wrap_count", obs_s.size(), 1);

        // Disabled ticks: phase holds, no pulses, tick grid unchanged on resume
        clear_obs();
        step = 16'h1234;
        wait_ticks(3);
        check_eq("t5_phase_hold", 32'(p_main), 32'h0000);
        check_eq("t5_no_pulses", obs_s.size(), 0);
        en = 1'b1;
        wait_ticks(4);
        en = 1'b0;
        drain();
        check_eq("t5_resume_count", obs_s.size(), 4);
        check_eq("t5_resume_phase", 32'(p_main), 32'h48D0);

        // Random increments against the model
        for (int r = 0; r < 4; r++) begin
            step = 16'($urandom);
            en   = 1'b1;
            wait_ticks(3);
            en = 1'b0;
            drain();
            check_eq("rand_phase", 32'(p_main), 32'(m_phase));
        end

        // Reset one cycle after an enabled tick discards the in-flight sample
        step = 16'h4000;
        en   = 1'b1;
        wait_ticks(1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_sample", 32'(s_main), 32'd128);
        check_eq("t6_valid",  32'(v_main), 32'd0);
        check_eq("t6_phase",  32'(p_main), 32'd0);
        rst = 1'b0;
        en  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t6_no_valid", 32'(v_main), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not reach the summary, got %0d checks expected completion", n_checks);
        $fatal(1);
    end

endmodule
